// File: rtl/rt_pkg.sv
// Shared ray-trace pipeline types: pixel format, framebuffer FSM states and default raster size.
// Also used by the scan-out block, so keep H_RES/V_RES here as the single source.
package rt_pkg;

  localparam int H_RES = 320;
  localparam int V_RES = 180;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_SWAP
  } fb_state_e;

  function automatic logic [15:0] pack_rgb565(input rgb24_t p);
    return {p.r[7:3], p.g[7:2], p.b[7:3]};
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: x/y plus a running linear index y*H_RES+x, no multiplier.
// All outputs registered; advances by one pixel per cycle with advance high, wraps after the last pixel.
module raster_counter #(
  parameter int H_RES = 320,
  parameter int V_RES = 180,
  parameter int XW    = (H_RES > 1) ? $clog2(H_RES) : 1,
  parameter int YW    = (V_RES > 1) ? $clog2(V_RES) : 1,
  parameter int IW    = (H_RES * V_RES > 1) ? $clog2(H_RES * V_RES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic x_end;

  assign x_end = (x == XW'(H_RES - 1));
  assign last  = x_end && (y == YW'(V_RES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x   <= '0;
      y   <= '0;
      idx <= '0;
    end else if (advance) begin
      if (last) begin
        x   <= '0;
        y   <= '0;
        idx <= '0;
      end else if (x_end) begin
        x   <= '0;
        y   <= y + 1'b1;
        idx <= idx + 1'b1;
      end else begin
        x   <= x + 1'b1;
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Packs the shaded 24-bit pixel stream to RGB565 into a double-buffered framebuffer; write latency 1.
// tready is high only while drawing a frame; buffers swap in vblank after the last pixel is written.
module pixel_fb_writer #(
  parameter int H_RES  = rt_pkg::H_RES,
  parameter int V_RES  = rt_pkg::V_RES,
  parameter int ADDR_W = $clog2(H_RES * V_RES) + 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              frame_start,
  input  logic [23:0]       pixel_axis_tdata,
  input  logic              pixel_axis_tvalid,
  output logic              pixel_axis_tready,
  input  logic              display_vblank,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_wdata,
  output logic              display_buf,
  output logic              frame_done,
  output logic              busy
);

  import rt_pkg::*;

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  fb_state_e         state;
  fb_state_e         state_next;
  logic              tready_q;
  logic              write_buf;
  logic              accept;
  logic              swap;
  logic              cnt_clear;
  logic [XW-1:0]     x_pos;
  logic [YW-1:0]     y_pos;
  logic [ADDR_W-2:0] idx;
  logic              last_px;

  assign accept    = pixel_axis_tvalid && tready_q;
  assign cnt_clear = (state == IDLE) && frame_start;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .XW    (XW),
    .YW    (YW),
    .IW    (ADDR_W - 1)
  ) u_raster_counter (
    .clk     (aclk),
    .rst     (areset),
    .advance (accept),
    .clear   (cnt_clear),
    .x       (x_pos),
    .y       (y_pos),
    .idx     (idx),
    .last    (last_px)
  );

  always_comb begin
    state_next = state;
    swap       = 1'b0;
    case (state)
      IDLE:      if (frame_start) state_next = WRITE;
      WRITE:     if (accept && last_px) state_next = WAIT_SWAP;
      WAIT_SWAP: begin
        if (display_vblank) begin
          state_next = IDLE;
          swap       = 1'b1;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      tready_q   <= 1'b0;
      write_buf  <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      tready_q   <= (state_next == WRITE);
      fb_we      <= accept;
      frame_done <= swap;
      if (accept) begin
        fb_addr  <= {write_buf, idx};
        fb_wdata <= pack_rgb565(rgb24_t'(pixel_axis_tdata));
      end
      if (swap) write_buf <= ~write_buf;
    end
  end

  // Raster position must stay inside the visible frame.
  always_ff @(posedge aclk) begin
    if (!areset) begin
      assert (x_pos <= XW'(H_RES - 1) && y_pos <= YW'(V_RES - 1));
    end
  end

  assign pixel_axis_tready = tready_q;
  assign display_buf       = ~write_buf;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer on a 4x3 raster: addressing, packing, gaps, swap and reset abort.
module tb_pixel_fb_writer;

  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;
  localparam int AW = $clog2(N) + 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic          frame_start;
  logic [23:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic          vblank;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_wdata;
  logic          display_buf;
  logic          frame_done;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  pixel_fb_writer #(.H_RES(H), .V_RES(V)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .frame_start       (frame_start),
    .pixel_axis_tdata  (tdata),
    .pixel_axis_tvalid (tvalid),
    .pixel_axis_tready (tready),
    .display_vblank    (vblank),
    .fb_we             (fb_we),
    .fb_addr           (fb_addr),
    .fb_wdata          (fb_wdata),
    .display_buf       (display_buf),
    .frame_done        (frame_done),
    .busy              (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [23:0] pix(input int i);
    logic [23:0] p;
    if (i == 6) p = 24'hFF8040;
    else p = {8'(i * 21), 8'(255 - i * 13), 8'(i * 37 + 5)};
    return p;
  endfunction

  function automatic logic [15:0] rgb565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("start_busy", busy, 1);
    check("start_rdy", tready, 1);
  endtask

  // Drives nbeats pixels (optionally with random gaps) and checks each write one cycle later.
  task automatic run_frame(input int gap, input logic bufbit, input int fs_at, input int nbeats);
    int  i;
    int  cyc;
    bit  acc;
    i   = 0;
    cyc = 0;
    while (i < nbeats && cyc < 400) begin
      frame_start = (cyc == fs_at);
      if (gap > 0 && $urandom_range(1, 100) <= gap) begin
        tvalid = 1'b0;
        tdata  = 24'h0;
      end else begin
        tvalid = 1'b1;
        tdata  = pix(i);
      end
      acc = tvalid && tready;
      tick();
      cyc++;
      if (acc) begin
        check("wr_we", fb_we, 1);
        check("wr_addr", fb_addr, (bufbit ? 16 : 0) + i);
        check("wr_data", fb_wdata, rgb565(pix(i)));
        if (i == 6) check("px6_data", fb_wdata, 16'hFC08);
        i++;
      end else begin
        check("gap_no_we", fb_we, 0);
      end
    end
    frame_start = 1'b0;
    tvalid      = 1'b0;
    if (i < nbeats) check("frame_timeout", i, nbeats);
    if (nbeats == N) begin
      check("rdy_drop", tready, 0);
      check("busy_wait", busy, 1);
    end
  endtask

  initial begin
    areset      = 1'b1;
    frame_start = 1'b0;
    tdata       = 24'h0;
    tvalid      = 1'b0;
    vblank      = 1'b0;
    repeat (3) tick();
    check("rst_rdy", tready, 0);
    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_wdata", fb_wdata, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_dbuf", display_buf, 1);
    areset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Back-to-back frame into buffer 0, then 20 cycles without vblank while upstream keeps pushing.
    start_frame();
    run_frame(0, 1'b0, -1, N);
    tvalid = 1'b1;
    tdata  = 24'h123456;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("wait_busy", busy, 1);
      check("wait_dbuf", display_buf, 1);
      check("wait_done", frame_done, 0);
      check("wait_we", fb_we, 0);
      check("wait_rdy", tready, 0);
    end
    tvalid      = 1'b0;
    vblank      = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    vblank      = 1'b0;
    check("swap_done", frame_done, 1);
    check("swap_dbuf", display_buf, 0);
    check("swap_busy", busy, 0);
    tick();
    check("done_pulse", frame_done, 0);
    check("fs_dropped", busy, 0);

    // Gappy frame into buffer 1 with vblank already high before completion.
    vblank = 1'b1;
    start_frame();
    run_frame(50, 1'b1, -1, N);
    tick();
    check("early_vb_done", frame_done, 1);
    check("early_vb_dbuf", display_buf, 1);
    vblank = 1'b0;
    tick();

    // frame_start pulses in WRITE and in WAIT_SWAP are ignored.
    start_frame();
    run_frame(0, 1'b0, 4, N);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("fs_ws_busy", busy, 1);
    check("fs_ws_rdy", tready, 0);
    check("fs_ws_we", fb_we, 0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    check("fs_swap_done", frame_done, 1);
    check("fs_swap_dbuf", display_buf, 0);
    tick();
    check("fs_noqueue_busy", busy, 0);
    check("fs_noqueue_rdy", tready, 0);

    // Reset mid-frame (buffer 1) after beat 5 aborts without a swap.
    start_frame();
    run_frame(0, 1'b1, -1, 5);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("abort_rdy", tready, 0);
    check("abort_we", fb_we, 0);
    check("abort_addr", fb_addr, 0);
    check("abort_wdata", fb_wdata, 0);
    check("abort_busy", busy, 0);
    check("abort_dbuf", display_buf, 1);
    check("abort_done", frame_done, 0);
    vblank = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("abort_no_done", frame_done, 0);
      check("abort_idle", busy, 0);
    end
    vblank = 1'b0;
    start_frame();
    run_frame(0, 1'b0, -1, N);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    check("post_rst_done", frame_done, 1);
    check("post_rst_dbuf", display_buf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
